// File: rtl/uart_frame_pkg.sv
// Shared definitions for the parameter command frame (tx encoder and rx decoder).
// Holds the frame layout, FSM encoding and byte/checksum helpers.
package uart_frame_pkg;

  localparam int unsigned FRAME_LEN         = 11;
  localparam logic [3:0]  IDX_SYNC          = 4'd0;
  localparam logic [3:0]  IDX_SIG           = 4'd1;
  localparam logic [3:0]  IDX_ADD0          = 4'd2;
  localparam logic [3:0]  IDX_AMP0          = 4'd6;
  localparam logic [3:0]  IDX_CSUM          = 4'd10;
  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_SEND = 2'd1;
  localparam logic [1:0]  ST_GAP  = 2'd2;

  // XOR of every payload byte (indices 1..9)
  function automatic logic [7:0] frame_csum(
    input logic [7:0]  sig,
    input logic [31:0] add,
    input logic [31:0] amp
  );
    return sig ^ add[7:0] ^ add[15:8] ^ add[23:16] ^ add[31:24]
               ^ amp[7:0] ^ amp[15:8] ^ amp[23:16] ^ amp[31:24];
  endfunction

  function automatic logic [7:0] frame_byte(
    input logic [3:0]  idx,
    input logic [7:0]  sync,
    input logic [7:0]  sig,
    input logic [31:0] add,
    input logic [31:0] amp,
    input logic [7:0]  csum
  );
    logic [7:0] b;
    case (idx)
      IDX_SYNC:         b = sync;
      IDX_SIG:          b = sig;
      IDX_ADD0:         b = add[7:0];
      IDX_ADD0 + 4'd1:  b = add[15:8];
      IDX_ADD0 + 4'd2:  b = add[23:16];
      IDX_ADD0 + 4'd3:  b = add[31:24];
      IDX_AMP0:         b = amp[7:0];
      IDX_AMP0 + 4'd1:  b = amp[15:8];
      IDX_AMP0 + 4'd2:  b = amp[23:16];
      IDX_AMP0 + 4'd3:  b = amp[31:24];
      IDX_CSUM:         b = csum;
      default:          b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_param_frame_tx.sv
// Parameter frame encoder: snapshots the parameter set on start and streams
// the 11-byte frame over a valid/ready byte interface toward the UART wrapper.
module uart_param_frame_tx
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  signalNumber,
  input  logic [31:0] adder,
  input  logic [31:0] amplitude,
  output logic [7:0]  to_uart_data,
  output logic        to_uart_valid,
  input  logic        to_uart_ready,
  output logic        to_uart_error,
  output logic        busy,
  output logic        done,
  output logic        start_dropped
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  logic [1:0]  r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_sig;
  logic [31:0] r_add;
  logic [31:0] r_amp;
  logic [7:0]  r_csum;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_drop;

  logic        w_xfer;
  logic        w_last;
  logic [3:0]  w_next_idx;
  logic [7:0]  w_next_byte;

  assign w_xfer      = r_valid && to_uart_ready;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_next_idx  = r_idx + 4'd1;
  // Next byte is prepared from the snapshot so the data register updates with no bubble
  assign w_next_byte = frame_byte(w_next_idx, SYNC_BYTE, r_sig, r_add, r_amp, r_csum);

  // Frame sequencer: snapshot, byte stepping, end-of-frame pulses and inter-frame gap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= 4'd0;
      r_sig     <= 8'h00;
      r_add     <= 32'h0000_0000;
      r_amp     <= 32'h0000_0000;
      r_csum    <= 8'h00;
      r_gap_cnt <= 8'd0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_drop <= start && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sig   <= signalNumber;
            r_add   <= adder;
            r_amp   <= amplitude;
            r_csum  <= frame_csum(signalNumber, adder, amplitude);
            r_idx   <= IDX_SYNC;
            r_data  <= SYNC_BYTE;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_idx   <= 4'd0;
              if (GAP_CYCLES > 0) begin
                r_gap_cnt <= 8'd0;
                r_state   <= ST_GAP;
              end else begin
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end else begin
              r_idx  <= w_next_idx;
              r_data <= w_next_byte;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= 8'd0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign to_uart_data  = r_data;
  assign to_uart_valid = r_valid;
  assign to_uart_error = 1'b0;
  assign busy          = r_busy;
  assign done          = r_done;
  assign start_dropped = r_drop;

endmodule

// File: tb/tb_uart_param_frame_tx.sv
// Directed bench for uart_param_frame_tx: one instance with no gap, one with a
// 3-cycle gap, expected frames written out by hand.
module tb_uart_param_frame_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0;
  logic        start3;
  logic [7:0]  sig;
  logic [31:0] add;
  logic [31:0] amp;
  logic        ready;

  logic [7:0]  d0, d3;
  logic        v0, v3, e0, e3, b0, b3, dn0, dn3, dr0, dr3;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_frame [11];
  logic [7:0] q0 [$];
  int         stab_err0 = 0;
  int         done_cnt0 = 0;
  int         drop_cnt0 = 0;
  int         done_cnt3 = 0;
  int         err_cnt   = 0;
  logic       hold0     = 1'b0;
  logic [7:0] hold_d0   = 8'h00;

  logic        bp_mode = 1'b0;
  logic [15:0] bp_pat  = 16'b1001_0110_1100_1001;
  int          bp_i    = 0;

  always #5 clk = ~clk;

  uart_param_frame_tx #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .signalNumber(sig), .adder(add), .amplitude(amp),
    .to_uart_data(d0), .to_uart_valid(v0), .to_uart_ready(ready),
    .to_uart_error(e0), .busy(b0), .done(dn0), .start_dropped(dr0)
  );

  uart_param_frame_tx #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .signalNumber(sig), .adder(add), .amplitude(amp),
    .to_uart_data(d3), .to_uart_valid(v3), .to_uart_ready(ready),
    .to_uart_error(e3), .busy(b3), .done(dn3), .start_dropped(dr3)
  );

  // Negedge monitor: records transfers, hold stability and pulse counts
  always @(negedge clk) begin
    if (v0 && ready) q0.push_back(d0);
    if (hold0 && (!v0 || d0 !== hold_d0)) stab_err0++;
    hold0   = v0 && !ready;
    hold_d0 = d0;
    if (dn0) done_cnt0++;
    if (dr0) drop_cnt0++;
    if (dn3) done_cnt3++;
    if (e0 || e3) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_mode) begin
      ready = bp_pat[bp_i];
      bp_i  = (bp_i + 1) % 16;
    end
  endtask

  // One frame on dut0 with ready high, byte-exact per cycle
  task automatic run_frame0(input string tag);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      check_eq($sformatf("%s_valid%0d", tag, i), {31'd0, v0}, 32'd1);
      check_eq($sformatf("%s_byte%0d", tag, i), {24'd0, d0}, {24'd0, exp_frame[i]});
      tick();
    end
    check_eq({tag, "_done"}, {31'd0, dn0}, 32'd1);
    check_eq({tag, "_busy_low"}, {31'd0, b0}, 32'd0);
    check_eq({tag, "_valid_low"}, {31'd0, v0}, 32'd0);
  endtask

  initial begin
    int n;
    int dc;
    int drc;
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc;
    int drc;
    reset  = 1'b1;
    start0 = 1'b0;
    start3 = 1'b0;
    ready  = 1'b1;
    sig    = 8'h03;
    add    = 32'h0102_0304;
    amp    = 32'h0000_FFFF;
    repeat (3) tick();

    check_eq("rst_data",  {24'd0, d0}, 32'd0);
    check_eq("rst_valid", {31'd0, v0}, 32'd0);
    check_eq("rst_busy",  {31'd0, b0}, 32'd0);
    check_eq("rst_done",  {31'd0, dn0}, 32'd0);
    check_eq("rst_drop",  {31'd0, dr0}, 32'd0);
    check_eq("rst_err",   {31'd0, e0}, 32'd0);
    check_eq("rst_busy3", {31'd0, b3}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic frame
    exp_frame = '{8'hA5, 8'h03, 8'h04, 8'h03, 8'h02, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h07};
    run_frame0("basic");
    tick();

    // Backpressure
    q0.delete();
    stab_err0 = 0;
    dc = done_cnt0;
    bp_mode = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = 0;
    while (!dn0 && n < 300) begin
      tick();
      n++;
    end
    check_eq("bp_done_seen", {31'd0, dn0}, 32'd1);
    bp_mode = 1'b0;
    ready = 1'b1;
    tick();
    check_eq("bp_count", q0.size(), 32'd11);
    for (int i = 0; i < 11; i++) begin
      if (i < q0.size())
        check_eq($sformatf("bp_byte%0d", i), {24'd0, q0[i]}, {24'd0, exp_frame[i]});
    end
    check_eq("bp_stable", stab_err0, 32'd0);
    check_eq("bp_done_once", done_cnt0 - dc, 32'd1);

    // Snapshot and drop at byte index 4
    q0.delete();
    dc  = done_cnt0;
    drc = drop_cnt0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      check_eq($sformatf("snap_byte%0d", i), {24'd0, d0}, {24'd0, exp_frame[i]});
      if (i == 4) begin
        add    = 32'hDEAD_BEEF;
        start0 = 1'b1;
      end
      tick();
      if (i == 4) begin
        start0 = 1'b0;
        check_eq("snap_drop_pulse", {31'd0, dr0}, 32'd1);
      end
    end
    check_eq("snap_done", {31'd0, dn0}, 32'd1);
    repeat (5) tick();
    check_eq("snap_no_second", {31'd0, v0}, 32'd0);
    check_eq("snap_q_size", q0.size(), 32'd11);
    check_eq("snap_drop_once", drop_cnt0 - drc, 32'd1);
    check_eq("snap_done_once", done_cnt0 - dc, 32'd1);
    add = 32'h0102_0304;

    // Back-to-back, GAP_CYCLES=0: start held across final transfer and done cycle
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      check_eq($sformatf("b2b_byte%0d", i), {24'd0, d0}, {24'd0, exp_frame[i]});
      if (i == 10) start0 = 1'b1;
      tick();
    end
    check_eq("b2b_done", {31'd0, dn0}, 32'd1);
    check_eq("b2b_drop_last", {31'd0, dr0}, 32'd1);
    check_eq("b2b_busy_low", {31'd0, b0}, 32'd0);
    tick();
    start0 = 1'b0;
    check_eq("b2b_sync_valid", {31'd0, v0}, 32'd1);
    check_eq("b2b_sync", {24'd0, d0}, 32'hA5);
    check_eq("b2b_no_drop", {31'd0, dr0}, 32'd0);
    for (int i = 1; i < 11; i++) begin
      tick();
      check_eq($sformatf("b2b2_byte%0d", i), {24'd0, d0}, {24'd0, exp_frame[i]});
    end
    tick();
    check_eq("b2b2_done", {31'd0, dn0}, 32'd1);
    tick();

    // GAP_CYCLES=3 on dut3
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check_eq("gap_sync", {24'd0, d3}, 32'hA5);
    repeat (11) tick();
    check_eq("gap_done", {31'd0, dn3}, 32'd1);
    check_eq("gap_busy1", {31'd0, b3}, 32'd1);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check_eq("gap_drop", {31'd0, dr3}, 32'd1);
    check_eq("gap_busy2", {31'd0, b3}, 32'd1);
    check_eq("gap_no_valid", {31'd0, v3}, 32'd0);
    tick();
    check_eq("gap_busy3", {31'd0, b3}, 32'd1);
    tick();
    check_eq("gap_busy_fall", {31'd0, b3}, 32'd0);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check_eq("gap_restart_valid", {31'd0, v3}, 32'd1);
    check_eq("gap_restart_sync", {24'd0, d3}, 32'hA5);
    repeat (11) tick();
    check_eq("gap_restart_done", {31'd0, dn3}, 32'd1);
    repeat (4) tick();

    // Reset at byte index 6
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (6) tick();
    check_eq("rstmid_byte6", {24'd0, d0}, 32'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rstmid_valid", {31'd0, v0}, 32'd0);
    check_eq("rstmid_done", {31'd0, dn0}, 32'd0);
    check_eq("rstmid_busy", {31'd0, b0}, 32'd0);
    dc = done_cnt0;
    repeat (3) tick();
    check_eq("rstmid_no_done", done_cnt0 - dc, 32'd0);
    run_frame0("rstmid_new");
    tick();

    // All-ones checksum
    sig = 8'hFF;
    add = 32'hFFFF_FFFF;
    amp = 32'hFFFF_FFFF;
    exp_frame = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame0("ones");
    tick();
    check_eq("err_never", err_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
